hdmi_pixel_feeder: RTL
======================

Name: hdmi_pixel_feeder

Overview:
- Pixel source that answers the video driver's pixel request interface (data_req / pix_data / almost_empty / video_vs) on the pixel clock.
- Prefetches 24-bit RGB pixels from a framebuffer read port into an internal FIFO, walking addresses linearly across the active frame.
- Restarts the frame on each video_vs rising edge.
- Reports underruns.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT
- DEPTH, 16, FIFO entries (power of two, >= 4)
- AE_LEVEL, 4, almost_empty asserted when FIFO count <= AE_LEVEL
- UF_COLOR, 24'h000000, pixel driven on underrun

Ports:
- pixel_clk, in, 1, sole clock
- sys_rst_n, in, 1, asynchronous active-low reset
- video_vs, in, 1, vertical sync from video driver, active high
- data_req, in, 1, pop one pixel
- pix_data, out, 24, pixel, valid the cycle after data_req
- almost_empty, out, 1, FIFO count <= AE_LEVEL
- fb_rd_req, out, 1, framebuffer read request
- fb_rd_addr, out, ADDR_W, read address
- fb_rd_gnt, in, 1, request accepted this cycle
- fb_rd_valid, in, 1, read data return; returns are in order, latency >= 1
- fb_rd_data, in, 24, returned pixel
- underflow_cnt, out, 16, saturating count of underrun pops
- frame_done, out, 1, one-cycle pulse when the last address of a frame is granted

Behaviour:
- Reset values:
  - pix_data = UF_COLOR
  - almost_empty = 1
  - fb_rd_req = 0
  - fb_rd_addr = 0
  - underflow_cnt = 0
  - frame_done = 0
  - FIFO count, in-flight count and discard count = 0
  - state = IDLE
- Frame start (vs_rise): video_vs registered once; vs_rise = video_vs & ~vs_q.
- States:
  - IDLE: no requests. On vs_rise -> FLUSH.
  - FLUSH: FIFO cleared; in-flight reads moved to discard count; addr = 0. Go to FETCH when discard count reaches 0 (same cycle if it is already 0).
  - FETCH: issue reads. After the grant of address H_ACT*V_ACT-1: frame_done pulses, go to DRAIN.
  - DRAIN: no requests. Pops continue. vs_rise -> FLUSH.
  - vs_rise in any state other than IDLE -> FLUSH, including mid-FETCH.
- Request rule:
  - fb_rd_req = (state==FETCH) && (fifo_count + inflight < DEPTH).
  - On fb_rd_gnt: addr increments and inflight increments.
  - req/addr may change only after a grant or on a state change.
- Return rule:
  - fb_rd_valid with discard count > 0: data dropped, discard count decrements.
  - Otherwise: data pushed to FIFO, inflight decrements.
  - No overflow is possible by the credit rule. A push when full is a design error; assert it in simulation.
- Pop rule:
  - data_req with FIFO non-empty: pix_data <= head on the next edge, pop.
  - data_req with FIFO empty: pix_data <= UF_COLOR, underflow_cnt increments, saturating at 16'hFFFF.
  - No data_req: pix_data holds.
- Simultaneous push and pop in the same cycle: count unchanged; pass-through is allowed only from an entry already stored (no same-cycle bypass).
- vs_rise coinciding with pop/push: flush takes priority; the pop returns UF_COLOR without counting an underflow; a valid return that cycle counts toward discard.
- almost_empty is combinational from the registered count.
- underflow_cnt is cleared only by reset.
- Mid-operation reset: all state returns to reset values immediately (asynchronous).
- Pointers wrap modulo DEPTH. Address never exceeds H_ACT*V_ACT-1.

Test Plan:
- Reset then vs pulse, memory model with fixed latency 3 and grant always 1 -> addresses 0,1,2… issued; fifo_count reaches 16; fb_rd_req drops; almost_empty = 0.
- After fill, data_req held for 640 cycles with memory data = address -> pix_data sequence 0..639, one cycle after each req; underflow_cnt = 0.
- Grant stalled (fb_rd_gnt = 0) while data_req continues for 20 cycles from full -> 16 valid pixels, then UF_COLOR; underflow_cnt = 4; almost_empty asserted once count <= 4.
- vs pulse mid-frame with 3 reads in flight -> those 3 returns are discarded; next pix_data popped corresponds to address 0; fb_rd_addr restarts at 0.
- Small frame (H_ACT=4, V_ACT=2) -> frame_done pulses once on the grant of address 7; no request issued in DRAIN; next vs restarts at 0.
- Underflow saturation (forced via 70000 empty pops) -> underflow_cnt stops at 65535.

Source files
------------

// File: rtl/hdmi_pixel_feeder.sv
// Framebuffer-to-video pixel feeder: prefetches RGB pixels for the active frame into a
// small FIFO and serves the video driver's pop requests, restarting on each vsync edge.
module hdmi_pixel_feeder #(
  parameter int          H_ACT    = 640,
  parameter int          V_ACT    = 480,
  parameter int          ADDR_W   = 19,
  parameter int          DEPTH    = 16,
  parameter int          AE_LEVEL = 4,
  parameter logic [23:0] UF_COLOR = 24'h000000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_vs,
  input  logic              data_req,
  output logic [23:0]       pix_data,
  output logic              almost_empty,
  output logic              fb_rd_req,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic              fb_rd_gnt,
  input  logic              fb_rd_valid,
  input  logic [23:0]       fb_rd_data,
  output logic [15:0]       underflow_cnt,
  output logic              frame_done
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FETCH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              vs_p1;
  logic              vs_rise;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W:0]    credit_used;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [23:0]       fifo_mem [DEPTH];
  logic              gnt_ok;
  logic              last_gnt;
  logic              push, pop, drop, underrun;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign vs_rise     = video_vs & ~vs_p1;
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign gnt_ok      = fb_rd_req & fb_rd_gnt;

  // Returns owed to an abandoned frame are dropped before anything is stored.
  assign drop     = fb_rd_valid && (discard_cnt != '0);
  assign push     = fb_rd_valid && (discard_cnt == '0) && !vs_rise;
  assign pop      = data_req && (fifo_count != '0) && !vs_rise;
  assign underrun = data_req && (fifo_count == '0) && !vs_rise;

  assign almost_empty = (fifo_count <= CNT_W'(AE_LEVEL));

  always_comb begin
    state_d   = state_q;
    fb_rd_req = 1'b0;
    last_gnt  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_FLUSH: if (discard_cnt == '0) state_d = S_FETCH;
      S_FETCH: begin
        fb_rd_req = (credit_used < (CNT_W + 1)'(DEPTH));
        if (fb_rd_req && fb_rd_gnt && (fb_rd_addr == LAST_ADDR)) begin
          last_gnt = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    if (vs_rise) begin
      state_d  = S_FLUSH;
      last_gnt = 1'b0;
    end
  end

  // Stage p1: control state, credits, pointers and the output pixel register.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      vs_p1         <= 1'b0;
      fifo_count    <= '0;
      inflight      <= '0;
      discard_cnt   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fb_rd_addr    <= '0;
      frame_done    <= 1'b0;
      underflow_cnt <= '0;
      pix_data      <= UF_COLOR;
    end else begin
      state_q    <= state_d;
      vs_p1      <= video_vs;
      frame_done <= last_gnt;
      if (underrun) underflow_cnt <= sat_inc16(underflow_cnt);

      if (vs_rise) begin
        // Everything still outstanding, including a grant or return this cycle, is abandoned.
        fifo_count  <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        inflight    <= '0;
        discard_cnt <= discard_cnt + inflight + CNT_W'(gnt_ok) - CNT_W'(fb_rd_valid);
        fb_rd_addr  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        inflight   <= inflight + CNT_W'(gnt_ok) - CNT_W'(push);
        if (drop) discard_cnt <= discard_cnt - CNT_W'(1);
        if (gnt_ok && (fb_rd_addr != LAST_ADDR)) fb_rd_addr <= fb_rd_addr + ADDR_W'(1);
      end

      if (data_req) pix_data <= pop ? fifo_mem[rd_ptr] : UF_COLOR;
    end
  end

  // Stage p1 storage: FIFO payload, written only from stored returns (no bypass path).
  always_ff @(posedge pixel_clk) begin
    if (push) fifo_mem[wr_ptr] <= fb_rd_data;
  end

  a_no_overflow: assert property (@(posedge pixel_clk) disable iff (!sys_rst_n)
    !(push && (fifo_count == CNT_W'(DEPTH))));

endmodule
